// File: rtl/bin_div.sv
// Sequential restoring divider: a 2*WIDTH-bit dividend by a WIDTH-bit divisor,
// one quotient bit per cycle. Results are held until the next completion.
module bin_div #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int              CW   = $clog2(2*WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(2*WIDTH-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_zero;
    logic [2*WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]       r_dsr;
    logic [WIDTH-1:0]       r_rem;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH+1:0]       w_diff;
    logic                   w_neg;
    logic [WIDTH-1:0]       w_rem_next;
    logic [2*WIDTH-1:0]     w_quo_next;
    logic                   w_unused;

    assign w_zero = (divisor == {WIDTH{1'b0}});
    assign w_last = (r_state == CALC) && (r_cnt == LAST);

    // Next-state decode; start is only honoured outside CALC.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? DONE : CALC;
                end else begin
                    w_next   = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = CALC;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // One restoring step: the dividend register doubles as the quotient
    // shift register, so the dividend MSB leaves as each quotient bit enters.
    always_comb begin
        w_shift    = {r_rem, r_dvd[2*WIDTH-1]};
        w_diff     = {1'b0, w_shift} - {2'b00, r_dsr};
        w_neg      = w_diff[WIDTH+1];
        w_rem_next = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quo_next = {r_dvd[2*WIDTH-2:0], ~w_neg};
    end

    // A surviving difference is below the divisor, so its top bit is always 0.
    assign w_unused = w_diff[WIDTH];

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == CALC);
            done    <= (w_next == DONE);
        end
    end

    // Working registers: loaded on acceptance, stepped while in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= {(2*WIDTH){1'b0}};
            r_dsr <= {WIDTH{1'b0}};
            r_rem <= {WIDTH{1'b0}};
            r_cnt <= {CW{1'b0}};
        end else if (w_accept) begin
            r_dvd <= dividend;
            r_dsr <= divisor;
            r_rem <= {WIDTH{1'b0}};
            r_cnt <= {CW{1'b0}};
        end else if (r_state == CALC) begin
            r_dvd <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_dvd <= r_dvd;
            r_dsr <= r_dsr;
            r_rem <= r_rem;
            r_cnt <= r_cnt;
        end
    end

    // Result registers change only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= {(2*WIDTH){1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else if (w_accept && w_zero) begin
            quotient    <= {(2*WIDTH){1'b1}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b1;
        end else if (w_last) begin
            quotient    <= w_quo_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
        end else begin
            quotient    <= quotient;
            remainder   <= remainder;
            div_by_zero <= div_by_zero;
        end
    end

endmodule

// File: tb/tb_bin_div.sv
// Self-checking bench for bin_div (WIDTH=4): directed cases plus random
// operations compared against plain integer division.
module tb_bin_div;

    localparam int W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic [31:0] exp_z;

    bin_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered and left at a negedge; returns one cycle after the accepting edge.
    task automatic start_op(input string tag, input logic [7:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        check({tag, "/busy"}, {31'd0, busy}, {31'd0, (b != 4'd0)});
        if (b != 4'd0) begin
            check({tag, "/held_q"}, {24'd0, quotient}, exp_q);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "/latency"}, n, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) begin
            exp_q = 32'd255;
            exp_r = 32'd0;
            exp_z = 32'd1;
        end else begin
            exp_q = 32'(int'(a) / int'(b));
            exp_r = 32'(int'(a) % int'(b));
            exp_z = 32'd0;
        end
        check({tag, "/q"},    {24'd0, quotient},    exp_q);
        check({tag, "/r"},    {28'd0, remainder},   exp_r);
        check({tag, "/dbz"},  {31'd0, div_by_zero}, exp_z);
        check({tag, "/busy0"}, {31'd0, busy},       32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b, input bit b2b);
        start_op(tag, a, b);
        wait_done(tag, (b == 4'd0) ? 0 : 8);
        check_result(tag, a, b);
        if (!b2b) begin
            tick();
            check({tag, "/pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int ndone;
        logic [7:0] a;
        logic [3:0] b;
        bit b2b;

        rst_n = 1'b0;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 4'd0;
        exp_q = 32'd0;
        exp_r = 32'd0;
        exp_z = 32'd0;
        tick();
        check("reset/q",    {24'd0, quotient},    32'd0);
        check("reset/r",    {28'd0, remainder},   32'd0);
        check("reset/busy", {31'd0, busy},        32'd0);
        check("reset/done", {31'd0, done},        32'd0);
        check("reset/dbz",  {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // Start on the very first edge after reset release.
        run_op("35/5", 8'd35, 4'd5, 1'b0);

        run_op("200/3", 8'd200, 4'd3, 1'b1);
        run_op("255/15", 8'd255, 4'd15, 1'b0);

        run_op("7/9", 8'd7, 4'd9, 1'b0);
        run_op("255/1", 8'd255, 4'd1, 1'b0);
        run_op("13/0", 8'd13, 4'd0, 1'b0);
        run_op("8/4", 8'd8, 4'd4, 1'b0);

        // Start pulsed mid-operation with different operands is ignored.
        start_op("busy_ign", 8'd100, 4'd7);
        tick();
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("busy_ign/busy", {31'd0, busy}, 32'd1);
        wait_done("busy_ign", 6);
        check_result("busy_ign", 8'd100, 4'd7);
        tick();

        // Asynchronous reset during the 4th CALC cycle aborts the operation.
        start_op("abort", 8'd150, 4'd7);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort/q",    {24'd0, quotient},    32'd0);
        check("abort/r",    {28'd0, remainder},   32'd0);
        check("abort/busy", {31'd0, busy},        32'd0);
        check("abort/done", {31'd0, done},        32'd0);
        check("abort/dbz",  {31'd0, div_by_zero}, 32'd0);
        exp_q = 32'd0;
        exp_r = 32'd0;
        exp_z = 32'd0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("abort/no_done", ndone, 0);
        run_op("72/9", 8'd72, 4'd9, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 4'($urandom_range(0, 15));
            b2b = (i < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_op("rand", a, b, b2b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_div.md
BIN_DIV -- requirements
Module: bin_div

Interface
REQ-001 SHALL have parameter WIDTH, default 4: divisor/remainder width; dividend and quotient are 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled on rising clk.
REQ-005 SHALL have port dividend  input  2*WIDTH  unsigned dividend, captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, captured when start is accepted.
REQ-007 SHALL have port quotient  output  2*WIDTH  registered quotient of the last completed operation.
REQ-008 SHALL have port remainder  output  WIDTH  registered remainder of the last completed operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port div_by_zero  output  1  flag for the last completed operation; valid from done onward.

Function
REQ-012 SHALL implement an FSM with exactly three states: IDLE, CALC and DONE.
REQ-013 SHALL accept start only when busy=0 (state IDLE or DONE); start SHALL be ignored while in CALC.
REQ-014 SHALL, on accepting start, capture dividend and divisor into internal working registers and clear a step counter.
REQ-015 SHALL, on accepting start with divisor!=0, enter CALC with busy=1 on the next cycle.
REQ-016 SHALL perform restoring division in CALC, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder.
REQ-017 SHALL, each CALC step: shift partial remainder left, bring in the next dividend bit, trial-subtract divisor; if non-negative keep the difference and set quotient bit 1, else restore and set quotient bit 0.
REQ-018 SHALL remain in CALC for exactly 2*WIDTH cycles, then enter DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, 2*WIDTH+1 cycles after the accepting edge (9 for WIDTH=4), with busy=0 in that cycle.
REQ-020 SHALL update quotient, remainder and div_by_zero only on entry to DONE; they SHALL hold their values in all other cycles, including throughout CALC.
REQ-021 SHALL, on accepting start with divisor==0, skip CALC, enter DONE on the next cycle and report quotient=all ones, remainder=0, div_by_zero=1.
REQ-022 SHALL clear div_by_zero on completion of any operation with a nonzero divisor.
REQ-023 SHALL go from DONE to IDLE on the next cycle unless start is high, in which case it SHALL accept start (back-to-back operation).
REQ-024 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor.
REQ-025 SHALL NOT alter an operation in progress when the dividend or divisor inputs change after acceptance.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: state IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; working registers and counter cleared.
REQ-027 SHALL abort any operation in progress when reset is asserted mid-operation, with no done pulse for the aborted operation.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL be verified: start with 35/5 -> done 9 cycles later, quotient=7, remainder=0, div_by_zero=0.
REQ-030 SHALL be verified: 200/3 then 255/15 back-to-back (start held high in DONE) -> 66 r2, then 17 r0, each with a one-cycle done pulse.
REQ-031 SHALL be verified: 7/9 -> quotient=0, remainder=7; and 255/1 -> quotient=255, remainder=0.
REQ-032 SHALL be verified: 13/0 -> done 1 cycle after start, quotient=8'hFF, remainder=0, div_by_zero=1; next 8/4 -> 2 r0, div_by_zero=0.
REQ-033 SHALL be verified: start pulsed while busy, with changed operands -> ignored, and the original result is reported on schedule.
REQ-034 SHALL be verified: rst_n pulsed low at the 4th CALC cycle -> outputs go to 0 asynchronously, no done pulse; a subsequent 72/9 -> 8 r0.
